// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite block-copy initiator.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam logic [3:0] WSTRB_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } xfer_state_t;

  function automatic logic [AXIL_ADDR_W-1:0] next_word_addr(input logic [AXIL_ADDR_W-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/axil_xfer.sv
// AXI4-Lite initiator copying len words from src_addr to dst_addr, one
// read/write/response round trip per word. All outputs are registered.
module axil_xfer
  import axil_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AXIL_ADDR_W-1:0] src_addr,
  input  logic [AXIL_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [AXIL_ADDR_W-1:0] AWADDR,
  output logic                   WVALID,
  input  logic                   WREADY,
  output logic [AXIL_DATA_W-1:0] WDATA,
  output logic [3:0]             WSTRB,
  input  logic                   BVALID,
  output logic                   BREADY,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  output logic [AXIL_ADDR_W-1:0] ARADDR,
  input  logic                   RVALID,
  output logic                   RREADY,
  input  logic [AXIL_DATA_W-1:0] RDATA
);

  xfer_state_t            state_r;
  logic [LEN_W-1:0]       cnt_r;
  logic [AXIL_ADDR_W-1:0] src_r;
  logic [AXIL_ADDR_W-1:0] dst_r;
  logic [AXIL_DATA_W-1:0] data_r;
  logic                   arvalid_r;
  logic                   rready_r;
  logic                   awvalid_r;
  logic                   wvalid_r;
  logic                   bready_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   aw_ok_r;
  logic                   w_ok_r;

  logic                   aw_hs_s;
  logic                   w_hs_s;
  logic                   aw_all_s;
  logic                   w_all_s;
  logic [LEN_W-1:0]       cnt_dec_s;

  // AW and W may be accepted in different cycles; each side remembers its own acceptance.
  assign aw_hs_s   = awvalid_r & AWREADY;
  assign w_hs_s    = wvalid_r & WREADY;
  assign aw_all_s  = aw_ok_r | aw_hs_s;
  assign w_all_s   = w_ok_r | w_hs_s;
  assign cnt_dec_s = cnt_r - LEN_W'(1);

  // Transfer sequencer: state, address/count bookkeeping and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {LEN_W{1'b0}};
      src_r     <= 32'd0;
      dst_r     <= 32'd0;
      data_r    <= 32'd0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aw_ok_r   <= 1'b0;
      w_ok_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            cnt_r  <= len;
            busy_r <= 1'b1;
            if (len == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r   <= ST_RADDR;
              arvalid_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RADDR: begin
          if (ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (RVALID) begin
            data_r    <= RDATA;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            aw_ok_r   <= 1'b0;
            w_ok_r    <= 1'b0;
            state_r   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_ok_r   <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_ok_r   <= 1'b1;
          end
          if (aw_all_s && w_all_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            bready_r <= 1'b0;
            src_r    <= next_word_addr(src_r);
            dst_r    <= next_word_addr(dst_r);
            cnt_r    <= cnt_dec_s;
            if (cnt_dec_s != {LEN_W{1'b0}}) begin
              arvalid_r <= 1'b1;
              state_r   <= ST_RADDR;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign ARVALID = arvalid_r;
  assign ARADDR  = src_r;
  assign RREADY  = rready_r;
  assign AWVALID = awvalid_r;
  assign AWADDR  = dst_r;
  assign WVALID  = wvalid_r;
  assign WDATA   = data_r;
  assign WSTRB   = WSTRB_ALL;
  assign BREADY  = bready_r;

endmodule

// File: tb/tb_axil_xfer.sv
// Bench for axil_xfer: a randomized AXI4-Lite responder with protocol monitor,
// and a list-of-words reference model of each block copy.
module tb_axil_xfer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;

  axil_xfer #(.LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // 0: zero-wait, 1: random stalls, 2: W accepted before AW, 3: AW before W
  int          mode = 0;
  logic [31:0] salt;
  logic [31:0] rd_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          split_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Responder + monitor: everything happens at the falling edge; a handshake
  // is logged when VALID and READY are both high ahead of the next rising edge.
  initial begin
    logic        rd_pend, r_hs, b_pend, b_hs, aw_got, w_got, prev_rst;
    logic [31:0] rd_addr;
    int          rd_wait, b_wait;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    RVALID = 1'b0; BVALID = 1'b0; RDATA = 32'd0;
    rd_pend = 1'b0; r_hs = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
    aw_got = 1'b0; w_got = 1'b0; prev_rst = 1'b0;
    rd_addr = 32'd0; rd_wait = 0; b_wait = 0;
    p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
    p_araddr = 32'd0; p_awaddr = 32'd0; p_wdata = 32'd0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RVALID = 1'b0; BVALID = 1'b0;
        rd_pend = 1'b0; r_hs = 1'b0; b_pend = 1'b0; b_hs = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; prev_rst = 1'b0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (prev_rst) begin
          if (p_arv && !p_arr) begin
            check("ar_valid_hold", {31'd0, ARVALID}, 32'd1);
            check("ar_addr_hold", ARADDR, p_araddr);
          end
          if (p_awv && !p_awr) begin
            check("aw_valid_hold", {31'd0, AWVALID}, 32'd1);
            check("aw_addr_hold", AWADDR, p_awaddr);
          end
          if (p_wv && !p_wr) begin
            check("w_valid_hold", {31'd0, WVALID}, 32'd1);
            check("w_data_hold", WDATA, p_wdata);
          end
          check("wstrb", {28'd0, WSTRB}, 32'hF);
        end
        if (aw_got && !w_got) begin
          check("split_aw_dropped", {31'd0, AWVALID}, 32'd0);
          check("split_w_waiting", {31'd0, WVALID}, 32'd1);
          check("split_busy", {31'd0, busy}, 32'd1);
          split_checks++;
        end
        if (w_got && !aw_got) begin
          check("split_w_dropped", {31'd0, WVALID}, 32'd0);
          check("split_aw_waiting", {31'd0, AWVALID}, 32'd1);
          check("split_busy", {31'd0, busy}, 32'd1);
          split_checks++;
        end
        if (r_hs) begin
          RVALID = 1'b0; r_hs = 1'b0; rd_pend = 1'b0;
        end else if (rd_pend && !RVALID) begin
          if (rd_wait == 0) begin
            RVALID = 1'b1;
            RDATA = memfn(rd_addr);
          end else begin
            rd_wait--;
          end
        end
        if (RVALID && RREADY === 1'b1) r_hs = 1'b1;
        ARREADY = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ARVALID === 1'b1 && ARREADY) begin
          rd_q.push_back(ARADDR);
          rd_addr = ARADDR;
          rd_pend = 1'b1;
          rd_wait = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
        if (b_hs) begin
          BVALID = 1'b0; b_hs = 1'b0; b_pend = 1'b0;
        end else if (b_pend && !BVALID) begin
          if (b_wait == 0) BVALID = 1'b1;
          else b_wait--;
        end
        if (BVALID && BREADY === 1'b1) b_hs = 1'b1;
        case (mode)
          1: begin AWREADY = 1'($urandom_range(0, 1)); WREADY = 1'($urandom_range(0, 1)); end
          2: begin WREADY = 1'b1; AWREADY = w_got; end
          3: begin AWREADY = 1'b1; WREADY = aw_got; end
          default: begin AWREADY = 1'b1; WREADY = 1'b1; end
        endcase
        if (AWVALID === 1'b1 && AWREADY) begin aw_q.push_back(AWADDR); aw_got = 1'b1; end
        if (WVALID === 1'b1 && WREADY) begin wd_q.push_back(WDATA); w_got = 1'b1; end
        if (aw_got && w_got) begin
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
          b_wait = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
        p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
        p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
        p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA;
        prev_rst = 1'b1;
      end
    end
  end

  // One block copy; exp_done < 0 skips the exact-latency check.
  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int exp_done, input bit poke);
    int          cyc;
    logic [31:0] exp_src, exp_dst;
    rd_q.delete(); aw_q.delete(); wd_q.delete();
    done_cnt = 0;
    @(negedge clock);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    check("arvalid_cycle1", {31'd0, ARVALID}, (n != 16'd0) ? 32'd1 : 32'd0);
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 600) begin
      if (poke && cyc == 6) begin
        start = 1'b1; src_addr = 32'hDEAD_0000; len = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (exp_done >= 0) check("done_cycle", cyc, exp_done);
    @(negedge clock);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (10) @(negedge clock);
    check("done_count", done_cnt, 32'd1);
    check("rd_count", rd_q.size(), {16'd0, n});
    check("aw_count", aw_q.size(), {16'd0, n});
    check("w_count", wd_q.size(), {16'd0, n});
    for (int i = 0; i < int'(n); i++) begin
      exp_src = s + 32'(4 * i);
      exp_dst = d + 32'(4 * i);
      if (i < rd_q.size()) check("rd_addr", rd_q[i], exp_src);
      if (i < aw_q.size()) check("wr_addr", aw_q[i], exp_dst);
      if (i < wd_q.size()) check("wr_data", wd_q[i], memfn(exp_src));
    end
  endtask

  initial begin
    int          k;
    logic [15:0] rl;
    salt = $urandom;
    reset = 1'b0; start = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
    repeat (3) @(negedge clock);
    check("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    check("rst_awvalid", {31'd0, AWVALID}, 32'd0);
    check("rst_wvalid", {31'd0, WVALID}, 32'd0);
    check("rst_rready", {31'd0, RREADY}, 32'd0);
    check("rst_bready", {31'd0, BREADY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_araddr", ARADDR, 32'd0);
    check("rst_awaddr", AWADDR, 32'd0);
    check("rst_wdata", WDATA, 32'd0);
    check("rst_wstrb", {28'd0, WSTRB}, 32'hF);
    reset = 1'b1;

    mode = 0;
    do_xfer(32'h0000_0100, 32'h0000_0200, 16'd3, 13, 1'b0);

    mode = 1;
    for (int t = 0; t < 5; t++) begin
      rl = 16'($urandom_range(1, 6));
      do_xfer({$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, rl, -1, 1'b0);
    end

    mode = 2;
    do_xfer(32'h0000_1000, 32'h0000_2000, 16'd2, 11, 1'b0);
    mode = 3;
    do_xfer(32'h0000_3000, 32'h0000_4000, 16'd2, 11, 1'b0);
    check("split_exercised", {31'd0, split_checks >= 4}, 32'd1);

    mode = 0;
    do_xfer(32'h0000_0500, 32'h0000_0600, 16'd0, 1, 1'b0);
    do_xfer(32'hFFFF_FFFC, 32'h0000_0800, 16'd2, 9, 1'b0);

    // Abort a transfer while the write request is pending.
    @(negedge clock);
    src_addr = 32'h0000_0A00; dst_addr = 32'h0000_0B00; len = 16'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (AWVALID !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("reached_write", {31'd0, AWVALID}, 32'd1);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_arvalid", {31'd0, ARVALID}, 32'd0);
    check("abort_awvalid", {31'd0, AWVALID}, 32'd0);
    check("abort_wvalid", {31'd0, WVALID}, 32'd0);
    check("abort_rready", {31'd0, RREADY}, 32'd0);
    check("abort_bready", {31'd0, BREADY}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b1;
    do_xfer(32'h0000_0C00, 32'h0000_0D00, 16'd2, 9, 1'b0);

    mode = 1;
    do_xfer(32'h0000_0E00, 32'h0000_0F00, 16'd4, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_xfer.md
# axil_xfer

AXI4-Lite initiator that copies a block of 32-bit words from a source address range to a destination address range. It connects directly to the read and write channels of the `mem` AXI4-Lite responder and is the traffic source for the axixfer example. It runs one word at a time: read one word, write it, wait for the write response, then move to the next address.

## Interface
Parameters:
- `LEN_W`, default 16: width of the transfer length in words.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_addr`  in  32  word-aligned source byte address.
- `dst_addr`  in  32  word-aligned destination byte address.
- `len`  in  LEN_W  number of words to copy.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `AWVALID` out 1, `AWREADY` in 1, `AWADDR` out 32: write address channel.
- `WVALID` out 1, `WREADY` in 1, `WDATA` out 32, `WSTRB` out 4: write data channel.
- `BVALID` in 1, `BREADY` out 1: write response channel.
- `ARVALID` out 1, `ARREADY` in 1, `ARADDR` out 32: read address channel.
- `RVALID` in 1, `RREADY` out 1, `RDATA` in 32: read data channel.

## Operation
- **States:** IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- **IDLE:**
  - On `start`, latch `src_addr`, `dst_addr` and `len`.
  - If `len`==0, go to DONE. Otherwise go to RADDR.
- **RADDR:**
  - `ARVALID`=1, `ARADDR` = current source address.
  - On `ARREADY`, go to RDATA.
- **RDATA:**
  - `RREADY`=1.
  - On `RVALID`, capture `RDATA` into the data register and go to WRITE.
- **WRITE:**
  - `AWVALID`=1 and `WVALID`=1; `WSTRB`=4'hF.
  - Each valid drops independently once its own ready has been seen.
  - Go to WRESP only after both handshakes have completed. They may complete in the same cycle or in different cycles.
- **WRESP:**
  - `BREADY`=1.
  - On `BVALID`: add 4 to both addresses and subtract 1 from the remaining count. Go to RADDR if the count is still nonzero, otherwise to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **`busy`:** 1 in every state except IDLE.
- **Address arithmetic:** 32-bit, wrapping modulo 2^32. The low two address bits are passed through unchanged and never checked.
- **`start` while not in IDLE:** ignored.
- **Reset mid-transfer:** all outputs return to their reset values on the next edge. Any outstanding transaction is abandoned.

## Timing
- **Reset values:** all VALID and READY outputs = 0; `busy`=0; `done`=0; `AWADDR`, `ARADDR` and `WDATA` = 0; `WSTRB`=4'hF.
- **Handshake rule:** once asserted, a VALID stays high and its address/data stay stable until the matching READY is sampled high.
- **No combinational paths** from any input to any output; VALID and READY outputs are driven directly from state.
- **Start latency:** with `start` at cycle 0, `ARVALID` first goes high in cycle 1.
- **Per-word latency:** with a zero-wait responder, a word takes 4 cycles: AR in c, R in c+1, AW/W in c+2, B in c+3. The next `ARVALID` comes in c+4.
- **Total latency:** `done` pulses 4·`len`+1 cycles after `start`, and `busy` falls in the cycle after `done`.
- **`len`=0:** `done` in cycle 1, `busy` high only in cycle 1, no bus activity.
- **Outstanding transactions:** at most one read and one write, never overlapping.

## Structure
- A shared package `axil_pkg` holds:
  - the `xfer_state_t` enum;
  - `AXIL_ADDR_W`=32, `AXIL_DATA_W`=32;
  - the constant `WSTRB_ALL`=4'hF.
- The block is a single module with no sub-module. The AW/W split-acceptance tracking is two flag bits inside WRITE.

## Test plan
- **Zero-wait copy:** `src`=0x100, `dst`=0x200, `len`=3, zero-wait responder. Reads go to 0x100, 0x104, 0x108 and writes to 0x200, 0x204, 0x208 with matching data. `done` pulses at cycle 13.
- **Backpressure:** random `ARREADY`/`AWREADY`/`WREADY` stalls and `RVALID`/`BVALID` delays. Check that VALIDs and payloads stay stable until accepted, AW and W are each accepted exactly once per word, and data is preserved.
- **Split write acceptance:** `WREADY` one cycle before `AWREADY`, then the reverse. `WVALID` (or `AWVALID`) drops after its own handshake, and the block stays in WRITE until the second handshake.
- **Length 0 and wrap:** `len`=0 gives a `done` pulse at cycle 1 and no VALIDs. `src`=0xFFFF_FFFC, `len`=2 gives reads at 0xFFFF_FFFC and then 0x0000_0000.
- **Reset mid-transfer:** `reset`=0 while in WRITE with `AWVALID`=1. On the next edge all VALIDs, `busy` and `done` are 0. A new `start` then runs normally.
- **Start while busy:** `start` during a `len`=4 transfer is ignored. Exactly 4 words are copied and there is one `done` pulse.
